// File: rtl/dmem_ctrl_if.sv
// Bus bundle between dmem_ctrl (master) and the external data memory (slave):
// valid/ack handshake with word address, byte enables and read/write data.
interface dmem_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory access stage: stalls the datapath while a load/store runs on the bus.
// Optional DMEM_MISALIGN_CHK_EN faults misaligned word accesses without a bus request.
module dmem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 32'd255,
    parameter int unsigned CNT_W          = 32'd8,
    parameter logic [31:0] FAULT_DATA     = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        ByteOp,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MemFault,
    dmem_ctrl_if.master bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    logic [1:0]       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             access_s, misalign_s, stall_s, ack_s, timeout_s;
    logic             is_load_r, byte_r;
    logic [1:0]       lane_r;
    logic [31:0]      read_data_r;
    logic             fault_r;
    logic             bus_req_r, bus_we_r;
    logic [31:0]      bus_addr_r, bus_wdata_r;
    logic [3:0]       bus_be_r;

    function automatic logic [3:0] byte_enable(input logic bop, input logic [1:0] lane);
        logic [3:0] be;
        if (bop) begin
            be = 4'b0001 << lane;
        end else begin
            be = 4'hF;
        end
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic bop, input logic [31:0] wd);
        return bop ? {4{wd[7:0]}} : wd;
    endfunction

    function automatic logic [31:0] load_format(input logic bop, input logic [1:0] lane,
                                                input logic [31:0] rd);
        logic [31:0] res;
        if (bop) begin
            case (lane)
                2'd0:    res = {24'h00_0000, rd[7:0]};
                2'd1:    res = {24'h00_0000, rd[15:8]};
                2'd2:    res = {24'h00_0000, rd[23:16]};
                2'd3:    res = {24'h00_0000, rd[31:24]};
                default: res = 32'h0000_0000;
            endcase
        end else begin
            res = rd;
        end
        return res;
    endfunction

    // Simultaneous read and write requests are handled as a write.
    assign access_s = MemRead | MemWrite;

`ifdef DMEM_MISALIGN_CHK_EN
    assign misalign_s = access_s & ~ByteOp & (ALUResult[1:0] != 2'b00);
`else
    assign misalign_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = S_IDLE;
        case (state_r)
            S_IDLE: begin
                if (misalign_s) begin
                    state_nxt_s = S_DONE;
                end else if (access_s) begin
                    state_nxt_s = S_REQ;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (ack_s || timeout_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_REQ;
                end
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Per-state decode; an ack wins over a timeout in the same cycle
    always_comb begin
        stall_s   = 1'b0;
        ack_s     = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            S_IDLE: stall_s = access_s;
            S_REQ: begin
                stall_s   = 1'b1;
                ack_s     = bus.bus_ack;
                timeout_s = ~bus.bus_ack & (cnt_r == CNT_LAST);
            end
            default: stall_s = 1'b0;
        endcase
    end

    // Access latch, timeout counter, bus drive and load-result capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'h0000_0000;
            bus_wdata_r <= 32'h0000_0000;
            bus_be_r    <= 4'h0;
            is_load_r   <= 1'b0;
            byte_r      <= 1'b0;
            lane_r      <= 2'b00;
            cnt_r       <= '0;
            read_data_r <= 32'h0000_0000;
            fault_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (misalign_s) begin
                        fault_r <= 1'b1;
                        if (!MemWrite) begin
                            read_data_r <= FAULT_DATA;
                        end
                    end else if (access_s) begin
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= MemWrite;
                        bus_addr_r  <= {ALUResult[31:2], 2'b00};
                        bus_be_r    <= byte_enable(ByteOp, ALUResult[1:0]);
                        bus_wdata_r <= store_data(ByteOp, WriteData);
                        is_load_r   <= ~MemWrite;
                        byte_r      <= ByteOp;
                        lane_r      <= ALUResult[1:0];
                        cnt_r       <= '0;
                    end
                end
                S_REQ: begin
                    if (ack_s) begin
                        bus_req_r <= 1'b0;
                        if (is_load_r) begin
                            read_data_r <= load_format(byte_r, lane_r, bus.bus_rdata);
                        end
                    end else if (timeout_s) begin
                        bus_req_r <= 1'b0;
                        fault_r   <= 1'b1;
                        if (is_load_r) begin
                            read_data_r <= FAULT_DATA;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: bus_req_r <= 1'b0;
            endcase
        end
    end

    // Stall is gated by reset so a held reset never freezes the datapath.
    assign Stall         = reset & stall_s;
    assign ReadData      = read_data_r;
    assign MemFault      = fault_r;
    assign bus.bus_req   = bus_req_r;
    assign bus.bus_we    = bus_we_r;
    assign bus.bus_addr  = bus_addr_r;
    assign bus.bus_wdata = bus_wdata_r;
    assign bus.bus_be    = bus_be_r;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed vector table, reset corner cases and
// randomized accesses checked against an access-level reference model.
module tb_dmem_ctrl;

    localparam int          T     = 4;
    localparam logic [31:0] FAULT = 32'hDEAD_BEEF;

    typedef struct {
        logic        rd, wr, bop;
        logic [31:0] addr, wdata, rdata;
        int          ack_cyc;       // REQ cycle (1-based) carrying the ack; 0 = never
    } vec_t;

    typedef struct {
        int          stall, req;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  be;
        logic        we, fault;
    } exp_t;

    typedef struct {
        vec_t v;
        exp_t e;
    } rec_t;

    typedef struct {
        int          stall_cnt, req_cnt;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  be;
        logic        we, fault, unstable, done, req_done;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, ByteOp;
    logic [31:0] ALUResult, WriteData, ReadData;
    logic        Stall, MemFault;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_rdata;
    logic        m_fault;

    dmem_ctrl_if bif ();

    dmem_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .MemRead(MemRead), .MemWrite(MemWrite), .ByteOp(ByteOp),
        .ALUResult(ALUResult), .WriteData(WriteData),
        .ReadData(ReadData), .Stall(Stall), .MemFault(MemFault),
        .bus(bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic rd, wr, bop, input logic [31:0] addr, wdata, rdata,
                                input int ack, st, rq, input logic [31:0] ea, ew, er,
                                input logic [3:0] be, input logic we, flt);
        rec_t r;
        r.v = '{rd, wr, bop, addr, wdata, rdata, ack};
        r.e = '{st, rq, ea, ew, er, be, we, flt};
        return r;
    endfunction

    // Access-level reference: latency, bus image and result from the access rules.
    task automatic model(input vec_t v, output exp_t e);
        logic [1:0] lane;
        bit mis, acked, is_load;
        lane = v.addr[1:0];
        mis  = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
        mis = !v.bop && (lane != 2'b00);
`endif
        acked   = !mis && (v.ack_cyc >= 1) && (v.ack_cyc <= T);
        is_load = v.rd && !v.wr;
        e.req   = mis ? 0 : (acked ? v.ack_cyc : T);
        e.stall = e.req + 1;
        e.addr  = v.addr & 32'hFFFF_FFFC;
        e.be    = v.bop ? (4'b0001 << lane) : 4'hF;
        e.wdata = v.bop ? {4{v.wdata[7:0]}} : v.wdata;
        e.we    = v.wr;
        if (is_load) begin
            if (acked) m_rdata = v.bop ? ((v.rdata >> (8 * int'(lane))) & 32'h0000_00FF) : v.rdata;
            else       m_rdata = FAULT;
        end
        if (!acked) m_fault = 1'b1;
        e.rdata = m_rdata;
        e.fault = m_fault;
    endtask

    // Entered and left #1 after a rising edge with the DUT idle.
    task automatic apply(input vec_t v, output obs_t o);
        o = '{0, 0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        MemRead = v.rd; MemWrite = v.wr; ByteOp = v.bop;
        ALUResult = v.addr; WriteData = v.wdata;
        for (int c = 0; c < 40 && !o.done; c++) begin
            @(negedge clk);
            if (Stall) o.stall_cnt++;
            if (bif.bus_req) begin
                o.req_cnt++;
                if (o.req_cnt == 1) begin
                    o.addr = bif.bus_addr; o.wdata = bif.bus_wdata;
                    o.be = bif.bus_be; o.we = bif.bus_we;
                end else if ({o.addr, o.wdata, o.be, o.we} !==
                             {bif.bus_addr, bif.bus_wdata, bif.bus_be, bif.bus_we}) begin
                    o.unstable = 1'b1;
                end
            end
            if (o.stall_cnt > 0 && !Stall) begin
                o.done = 1'b1; o.rdata = ReadData; o.fault = MemFault; o.req_done = bif.bus_req;
            end
            bif.bus_ack   = bif.bus_req && (o.req_cnt == v.ack_cyc);
            bif.bus_rdata = bif.bus_ack ? v.rdata : $urandom;
            @(posedge clk); #1;
            bif.bus_ack = 1'b0;
        end
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic compare(input string tag, input vec_t v, input obs_t o, input exp_t e);
        chk({tag, "_done"}, o.done, 1'b1);
        chk({tag, "_stall_cycles"}, o.stall_cnt, e.stall);
        chk({tag, "_req_cycles"}, o.req_cnt, e.req);
        if (e.req > 0) begin
            chk({tag, "_addr"}, o.addr, e.addr);
            chk({tag, "_be"}, o.be, e.be);
            chk({tag, "_we"}, o.we, e.we);
            chk({tag, "_stable"}, o.unstable, 1'b0);
            if (v.wr) chk({tag, "_wdata"}, o.wdata, e.wdata);
        end
        chk({tag, "_rdata"}, o.rdata, e.rdata);
        chk({tag, "_fault"}, o.fault, e.fault);
        chk({tag, "_req_in_done"}, o.req_done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t recs[9];
        obs_t o;
        exp_t e;
        vec_t v;

        recs[0] = mk(1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 32'h1234_5678, 1, 2, 1,
                     32'h104, 32'h0, 32'h1234_5678, 4'hF, 1'b0, 1'b0);
        recs[1] = mk(1'b0, 1'b1, 1'b1, 32'h203, 32'hAABB_CC5A, 32'h0, 4, 5, 4,
                     32'h200, 32'h5A5A_5A5A, 32'h1234_5678, 4'b1000, 1'b1, 1'b0);
        recs[2] = mk(1'b1, 1'b0, 1'b1, 32'h302, 32'h0, 32'h1122_3344, 2, 3, 2,
                     32'h300, 32'h0, 32'h0000_0022, 4'b0100, 1'b0, 1'b0);
        recs[3] = mk(1'b1, 1'b1, 1'b0, 32'h010, 32'hCAFE_F00D, 32'h7777_7777, 3, 4, 3,
                     32'h010, 32'hCAFE_F00D, 32'h0000_0022, 4'hF, 1'b1, 1'b0);
        recs[4] = mk(1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 32'h55AA_55AA, 4, 5, 4,
                     32'h600, 32'h0, 32'h55AA_55AA, 4'hF, 1'b0, 1'b0);
`ifdef DMEM_MISALIGN_CHK_EN
        recs[5] = mk(1'b1, 1'b0, 1'b0, 32'h101, 32'h0, 32'h0BAD_F00D, 1, 1, 0,
                     32'h0, 32'h0, FAULT, 4'h0, 1'b0, 1'b1);
`else
        recs[5] = mk(1'b1, 1'b0, 1'b0, 32'h101, 32'h0, 32'h0BAD_F00D, 1, 2, 1,
                     32'h100, 32'h0, 32'h0BAD_F00D, 4'hF, 1'b0, 1'b0);
`endif
        recs[6] = mk(1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0, 0, 5, 4,
                     32'h400, 32'h0, FAULT, 4'hF, 1'b0, 1'b1);
        recs[7] = mk(1'b1, 1'b0, 1'b1, 32'h401, 32'h0, 32'hA1B2_C3D4, 1, 2, 1,
                     32'h400, 32'h0, 32'h0000_00C3, 4'b0010, 1'b0, 1'b1);
        recs[8] = mk(1'b0, 1'b1, 1'b0, 32'h500, 32'h1357_2468, 32'h0, 0, 5, 4,
                     32'h500, 32'h1357_2468, 32'h0000_00C3, 4'hF, 1'b1, 1'b1);

        // Reset held with a pending load request
        reset = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; ByteOp = 1'b0;
        ALUResult = 32'h104; WriteData = 32'h0;
        bif.bus_ack = 1'b0; bif.bus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_req", bif.bus_req, 1'b0);
        chk("rst_stall", Stall, 1'b0);
        chk("rst_rdata", ReadData, 32'h0);
        chk("rst_fault", MemFault, 1'b0);
        chk("rst_bus_be", bif.bus_be, 4'h0);
        @(posedge clk); #1;
        MemRead = 1'b0; reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            apply(recs[i].v, o);
            compare($sformatf("vec%0d", i), recs[i].v, o, recs[i].e);
        end

        // Reset during REQ, then a late ack that must be ignored
        MemRead = 1'b1; ByteOp = 1'b0; ALUResult = 32'h700;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midreq_req_before_reset", bif.bus_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("midreq_req_dropped", bif.bus_req, 1'b0);
        chk("midreq_stall_dropped", Stall, 1'b0);
        MemRead = 1'b0; bif.bus_ack = 1'b1; bif.bus_rdata = 32'h9999_9999;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 bif.bus_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_bus_req", bif.bus_req, 1'b0);
        chk("late_ack_stall", Stall, 1'b0);
        chk("late_ack_rdata", ReadData, 32'h0);
        chk("late_ack_fault", MemFault, 1'b0);
        @(posedge clk); #1;
        m_rdata = 32'h0; m_fault = 1'b0;
        v = '{1'b1, 1'b0, 1'b0, 32'h710, 32'h0, 32'h0F0F_1234, 1};
        model(v, e);
        apply(v, o);
        compare("post_reset", v, o, e);

        // Randomized accesses against the reference model
        for (int i = 0; i < 60; i++) begin
            v.wr      = 1'($urandom_range(0, 1));
            v.rd      = v.wr ? 1'($urandom_range(0, 1)) : 1'b1;
            v.bop     = 1'($urandom_range(0, 1));
            v.addr    = $urandom;
            v.wdata   = $urandom;
            v.rdata   = $urandom;
            v.ack_cyc = $urandom_range(0, T + 1);
            model(v, e);
            apply(v, o);
            compare($sformatf("rnd%0d", i), v, o, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
